// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : Memory-access pipeline stage. Drives a req/ack data-memory port
//            with little-endian byte lanes, extends loads and registers the
//            writeback bundle. Optional ack watchdog: define MA_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int NBITS          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [NBITS-1:0] i_ALU_rslt,
    input  logic [NBITS-1:0] i_eff_addr,
    input  logic [NBITS-1:0] i_store_data,
    input  logic             i_flg_mem_op,
    input  logic             i_flg_mem_type,
    input  logic [1:0]       i_flg_mem_size,
    input  logic             i_flg_unsign,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rt,
    input  logic [1:0]       i_flg_ALU_dst,
    output logic             o_stall,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [NBITS-1:0] o_mem_addr,
    output logic [NBITS-1:0] o_mem_wdata,
    output logic [3:0]       o_mem_be,
    input  logic             i_mem_ack,
    input  logic [NBITS-1:0] i_mem_rdata,
    output logic             o_wb_valid,
    output logic             o_wb_en,
    output logic [4:0]       o_wb_reg,
    output logic [NBITS-1:0] o_wb_data,
    output logic             o_exc_misalign,
    output logic             o_exc_bus
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             mem_req_q, mem_we_q;
    logic [NBITS-1:0] mem_addr_q, mem_wdata_q;
    logic [3:0]       mem_be_q;
    logic [1:0]       size_q, lane_q;
    logic             unsign_q, store_q;
    logic [4:0]       rt_q;
    logic             wb_valid_q, wb_en_q, exc_mis_q;
    logic [4:0]       wb_reg_q;
    logic [NBITS-1:0] wb_data_q;

    logic             w_misalign, w_start, w_abort;
    logic [3:0]       w_be;
    logic [NBITS-1:0] w_wdata, w_load;
    logic [4:0]       w_alu_reg;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    // Size 2'b10 behaves as a word everywhere, hence the test on size[1].
    assign w_misalign = ((i_flg_mem_size == 2'b01) && i_eff_addr[0])
                     || (i_flg_mem_size[1] && (i_eff_addr[1:0] != 2'b00));
    assign w_start    = (state_q == c_IDLE) && i_valid && i_flg_mem_op && !w_misalign;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_store_data;
        case (i_flg_mem_size)
            2'b00: begin
                w_be    = 4'b0001 << i_eff_addr[1:0];
                w_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = i_eff_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_flg_ALU_dst)
            2'b01:   w_alu_reg = i_rd;
            2'b10:   w_alu_reg = i_rt;
            2'b11:   w_alu_reg = 5'd31;
            default: w_alu_reg = 5'd0;
        endcase
    end

    // Load extraction uses the lane and size captured at request time.
    always_comb begin
        w_byte = i_mem_rdata[{lane_q, 3'b000} +: 8];
        w_half = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (size_q)
            2'b00:   w_load = unsign_q ? {{(NBITS-8){1'b0}}, w_byte}
                                       : {{(NBITS-8){w_byte[7]}}, w_byte};
            2'b01:   w_load = unsign_q ? {{(NBITS-16){1'b0}}, w_half}
                                       : {{(NBITS-16){w_half[15]}}, w_half};
            default: w_load = i_mem_rdata;
        endcase
    end

`ifdef MA_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMO_W-1:0] tmo_cnt_q;
    logic               exc_bus_q;

    assign w_abort = (state_q == c_BUSY) && !i_mem_ack
                  && (tmo_cnt_q == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || (state_q != c_BUSY)) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + c_TMO_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            exc_bus_q <= 1'b0;
        end else begin
            exc_bus_q <= w_abort;
        end
    end

    assign o_exc_bus = exc_bus_q;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;

    assign w_abort   = 1'b0;
    assign o_exc_bus = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_start) state_d = c_BUSY;
            c_BUSY:  if (i_mem_ack || w_abort) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        o_stall = 1'b0;
        case (state_q)
            c_IDLE:  o_stall = w_start;
            c_BUSY:  o_stall = !i_mem_ack && !w_abort;
            default: o_stall = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            unsign_q    <= 1'b0;
            store_q     <= 1'b0;
            rt_q        <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_reg_q    <= 5'd0;
            wb_data_q   <= '0;
            exc_mis_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            exc_mis_q  <= 1'b0;
            if (state_q == c_IDLE) begin
                if (i_valid && !i_flg_mem_op) begin
                    wb_valid_q <= 1'b1;
                    wb_en_q    <= (w_alu_reg != 5'd0);
                    wb_reg_q   <= w_alu_reg;
                    wb_data_q  <= i_ALU_rslt;
                end else if (i_valid && w_misalign) begin
                    wb_valid_q <= 1'b1;
                    exc_mis_q  <= 1'b1;
                    wb_reg_q   <= i_rt;
                    wb_data_q  <= i_eff_addr;
                end else if (w_start) begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= i_flg_mem_type;
                    mem_addr_q  <= {i_eff_addr[NBITS-1:2], 2'b00};
                    mem_wdata_q <= w_wdata;
                    mem_be_q    <= w_be;
                    size_q      <= i_flg_mem_size;
                    lane_q      <= i_eff_addr[1:0];
                    unsign_q    <= i_flg_unsign;
                    store_q     <= i_flg_mem_type;
                    rt_q        <= i_rt;
                end
            end else if (i_mem_ack || w_abort) begin
                mem_req_q  <= 1'b0;
                mem_we_q   <= 1'b0;
                wb_valid_q <= 1'b1;
                wb_reg_q   <= rt_q;
                wb_en_q    <= i_mem_ack && !store_q && (rt_q != 5'd0);
                wb_data_q  <= (i_mem_ack && !store_q) ? w_load : '0;
            end
        end
    end

    assign o_mem_req      = mem_req_q;
    assign o_mem_we       = mem_we_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_wdata    = mem_wdata_q;
    assign o_mem_be       = mem_be_q;
    assign o_wb_valid     = wb_valid_q;
    assign o_wb_en        = wb_en_q;
    assign o_wb_reg       = wb_reg_q;
    assign o_wb_data      = wb_data_q;
    assign o_exc_misalign = exc_mis_q;

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access (MA) stage directly downstream of the EX/MA pipeline register.
- Consumes the latched ALU result, effective address, memory flags and destination fields, and drives a req/ack data-memory port with byte-lane alignment.
- Performs load extraction (sign/zero extension) and stalls upstream while a memory transaction is outstanding.
- Produces a registered writeback bundle for the MA/WB stage.

Parameters:
- NBITS, 32, datapath width (only 32 supported).
- TIMEOUT_CYCLES, 16, ack watchdog limit (used only with MA_TIMEOUT_EN).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  EX/MA bundle holds a live instruction
- i_ALU_rslt  in  NBITS  ALU result
- i_eff_addr  in  NBITS  effective memory address
- i_store_data  in  NBITS  rt value for stores
- i_flg_mem_op  in  1  1 = memory instruction
- i_flg_mem_type  in  1  0 = load, 1 = store
- i_flg_mem_size  in  2  00 = byte, 01 = half, 11 = word (10 treated as word)
- i_flg_unsign  in  1  1 = zero-extend loads
- i_rd, i_rt  in  5  register fields
- i_flg_ALU_dst  in  2  00 = none, 01 = rd, 10 = rt, 11 = r31
- o_stall  out  1  hold EX/MA and upstream stages
- o_mem_req, o_mem_we  out  1  memory request, write enable
- o_mem_addr  out  NBITS  word-aligned address ({eff_addr[31:2],2'b00})
- o_mem_wdata  out  NBITS  lane-replicated store data
- o_mem_be  out  4  byte enables
- i_mem_ack  in  1  memory completes current request
- i_mem_rdata  in  NBITS  read word, valid with ack
- o_wb_valid, o_wb_en  out  1  writeback bundle valid, register write
- o_wb_reg  out  5  destination register
- o_wb_data  out  NBITS  writeback value
- o_exc_misalign, o_exc_bus  out  1  exceptions, qualified by o_wb_valid

Behaviour:
- Reset: state IDLE. All outputs are 0, including o_stall, o_mem_req and o_wb_*.
- FSM has two states: IDLE and BUSY.
- Non-memory op (IDLE, i_valid, !mem_op):
  - 1-cycle latency: next cycle o_wb_valid=1 and o_wb_data=i_ALU_rslt.
  - o_wb_reg is selected by flg_ALU_dst (rd/rt/31). o_wb_en=0 for dst "none".
  - No stall.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - No memory request is issued.
  - Next cycle: o_wb_valid=1, o_exc_misalign=1, o_wb_en=0.
- Aligned memory op in IDLE:
  - o_stall=1 combinationally in that cycle.
  - All fields are latched and the FSM moves to BUSY.
  - o_mem_req=1 registered, with addr/we/be/wdata stable until ack.
- BUSY:
  - o_stall = !i_mem_ack.
  - On the ack cycle: next cycle o_mem_req=0, the FSM returns to IDLE, and o_wb_valid=1. Upstream advances on that same edge.
- Byte lanes are little-endian.
  - byte: be = 1<<addr[1:0], wdata = {4{data[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - word: be = 1111.
- Load data:
  - The selected byte or half is taken from i_mem_rdata at the addr lane.
  - It is sign-extended, or zero-extended when i_flg_unsign=1.
  - Destination is rt.
- Store: o_wb_valid=1, o_wb_en=0.
- Writes to register 0: o_wb_en is forced to 0.
- o_wb_valid is a 1-cycle pulse. It is 0 in any cycle without a completing instruction.
- i_mem_ack in IDLE is ignored.
- i_valid=0 in IDLE produces nothing.
- Reset mid-transaction: the FSM goes to IDLE, o_mem_req drops on the next edge, and the instruction is discarded (no wb pulse).

Optional Feature:
- Macro: MA_TIMEOUT_EN.
- When defined: a counter runs in BUSY. If no ack arrives after TIMEOUT_CYCLES cycles, the request is dropped and the FSM returns to IDLE. Next cycle o_wb_valid=1, o_exc_bus=1, o_wb_en=0, and o_stall is released in the abort cycle.
- When undefined: BUSY waits indefinitely, o_exc_bus is tied 0, and no counter exists.

Test Plan:
- ALU op, rslt=0x0000_1234, dst=01, rd=5 -> next cycle wb_valid=1, wb_en=1, wb_reg=5, wb_data=0x1234, stall never 1.
- LB signed, addr=0x0000_0103, ack after 3 cycles with rdata=0x80AA_BBCC -> req held 3 cycles, be=1000, stall=1 until ack cycle, then wb_data=0xFFFF_FF80, wb_reg=rt.
- SH, addr=0x0000_0042, store_data=0x1234_ABCD -> mem_addr=0x40, be=1100, wdata=0xABCD_ABCD, we=1; after ack wb_valid=1, wb_en=0.
- LW, addr=0x0000_0006 -> no req; next cycle wb_valid=1, exc_misalign=1, wb_en=0.
- LHU, addr=0x2, rdata=0xF00D_0000, rt=0 -> wb_data=0x0000_F00D, wb_en=0; separately, i_rst asserted while BUSY -> req=0 next cycle, no wb pulse.
- With MA_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never arrives -> req drops after 16 BUSY cycles, exc_bus=1, stall released.
